fft_peak_finder: RTL and testbench

- Sits directly downstream of the FFT magnitude stream inside the mic core.
- Scans each 4096-bin magnitude frame and finds the strongest bin within a configured band.
- Converts that bin to Hz and holds the result in registers for the slot read path; peak_hz replaces the hard-coded frequency constant.
- Checks frame integrity (index sequence and tlast position). Corrupt frames are discarded.

---
 rtl/fft_peak_finder.sv | 212 +++++++++++++++++++++
 tb/tb_fft_peak_finder.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_peak_finder.sv
// Finds the strongest in-band bin of each FFT magnitude frame and reports it in bins and Hz.
// Frames whose index sequence or tlast placement is broken are dropped and flagged in frame_err.
module fft_peak_finder #(
    parameter int unsigned MAG_W          = 24,
    parameter int unsigned IDX_W          = 12,
    parameter int unsigned FRAME_LEN      = 4096,
    parameter int unsigned MIN_BIN        = 1,
    parameter int unsigned MAX_BIN        = 2047,
    parameter int unsigned THRESH         = 256,
    parameter int unsigned HZ_PER_BIN_Q16 = 768000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [MAG_W-1:0] mag_tdata,
    input  logic [IDX_W-1:0] mag_tuser,
    input  logic             mag_tvalid,
    input  logic             mag_tlast,
    output logic             mag_tready,
    output logic [IDX_W-1:0] peak_bin,
    output logic [MAG_W-1:0] peak_mag,
    output logic [31:0]      peak_hz,
    output logic             peak_found,
    output logic             peak_valid,
    output logic             frame_err,
    output logic [15:0]      frame_cnt
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StScan   = 2'd1;
    localparam logic [1:0] StResync = 2'd2;

    localparam logic [IDX_W-1:0] LastIdx   = IDX_W'(FRAME_LEN - 1);
    localparam logic [IDX_W-1:0] MinIdx    = IDX_W'(MIN_BIN);
    localparam logic [IDX_W-1:0] MaxIdx    = IDX_W'(MAX_BIN);
    localparam logic [MAG_W-1:0] ThreshMag = MAG_W'(THRESH);
    localparam logic [43:0]      HzStep    = 44'(HZ_PER_BIN_Q16);

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] exp_idx_q, exp_idx_d;
    logic [IDX_W-1:0] best_bin_q, best_bin_d;
    logic [MAG_W-1:0] best_mag_q, best_mag_d;
    logic             ready_q;

    logic             accept;
    logic             is_first;
    logic             is_last_idx;
    logic             in_band;
    logic             candidate;
    logic             seq_bad;
    logic [IDX_W-1:0] base_bin;
    logic [MAG_W-1:0] base_mag;
    logic [IDX_W-1:0] eval_bin;
    logic [MAG_W-1:0] eval_mag;
    logic             err_set;
    logic             frame_done;

    // Result pipeline stages
    logic             done_q;
    logic             cap_valid_q;
    logic [IDX_W-1:0] cap_bin_q;
    logic [MAG_W-1:0] cap_mag_q;
    logic             cap_found_q;
    logic [43:0]      hz_prod;

    assign mag_tready = ready_q;
    assign accept     = mag_tvalid & ready_q;

    // Beat evaluation; an idx-0 beat restarts the search from 0/0
    always_comb begin
        is_first    = (mag_tuser == '0);
        is_last_idx = (mag_tuser == LastIdx);
        in_band     = (mag_tuser >= MinIdx) && (mag_tuser <= MaxIdx);
        base_bin    = is_first ? '0 : best_bin_q;
        base_mag    = is_first ? '0 : best_mag_q;
        candidate   = in_band && (mag_tdata > base_mag);
        eval_bin    = candidate ? mag_tuser : base_bin;
        eval_mag    = candidate ? mag_tdata : base_mag;
        seq_bad     = (mag_tuser != exp_idx_q) || (mag_tlast && !is_last_idx) ||
                      (is_last_idx && !mag_tlast);
    end

    always_comb begin
        state_d    = state_q;
        exp_idx_d  = exp_idx_q;
        best_bin_d = best_bin_q;
        best_mag_d = best_mag_q;
        err_set    = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (!is_first) begin
                        err_set = 1'b1;
                        state_d = mag_tlast ? StIdle : StResync;
                    end else if (mag_tlast) begin
                        // A one-beat frame can never be a complete frame
                        err_set = 1'b1;
                    end else begin
                        best_bin_d = eval_bin;
                        best_mag_d = eval_mag;
                        exp_idx_d  = IDX_W'(1);
                        state_d    = StScan;
                    end
                end
            end
            StScan: begin
                if (accept) begin
                    if (seq_bad) begin
                        err_set = 1'b1;
                        state_d = mag_tlast ? StIdle : StResync;
                    end else begin
                        best_bin_d = eval_bin;
                        best_mag_d = eval_mag;
                        exp_idx_d  = exp_idx_q + IDX_W'(1);
                        if (mag_tlast) begin
                            frame_done = 1'b1;
                            state_d    = StIdle;
                        end
                    end
                end
            end
            StResync: begin
                if (accept && mag_tlast) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            exp_idx_q  <= '0;
            best_bin_q <= '0;
            best_mag_q <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            exp_idx_q  <= exp_idx_d;
            best_bin_q <= best_bin_d;
            best_mag_q <= best_mag_d;
            ready_q    <= 1'b1;
        end
    end

    // E1: snapshot the finished frame before the next frame's idx 0 reinitialises best
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            done_q      <= 1'b0;
            cap_valid_q <= 1'b0;
            cap_bin_q   <= '0;
            cap_mag_q   <= '0;
            cap_found_q <= 1'b0;
        end else begin
            done_q      <= frame_done;
            cap_valid_q <= done_q;
            if (done_q) begin
                cap_bin_q   <= best_bin_q;
                cap_mag_q   <= best_mag_q;
                cap_found_q <= (best_mag_q >= ThreshMag);
            end
        end
    end

    assign hz_prod = 44'(cap_bin_q) * HzStep;

    // E2: publish results
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            peak_bin   <= '0;
            peak_mag   <= '0;
            peak_hz    <= '0;
            peak_found <= 1'b0;
            peak_valid <= 1'b0;
        end else begin
            peak_valid <= cap_valid_q;
            if (cap_valid_q) begin
                peak_found <= cap_found_q;
                if (cap_found_q) begin
                    peak_bin <= cap_bin_q;
                    peak_mag <= cap_mag_q;
                    peak_hz  <= 32'(hz_prod >> 16);
                end else begin
                    peak_bin <= '0;
                    peak_mag <= '0;
                    peak_hz  <= '0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_err <= 1'b0;
            frame_cnt <= '0;
        end else begin
            if (err_set) begin
                frame_err <= 1'b1;
            end else if (clear) begin
                frame_err <= 1'b0;
            end
            if (clear) begin
                frame_cnt <= '0;
            end else if (cap_valid_q) begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fft_peak_finder.sv
// Directed bench for fft_peak_finder: frames are driven beat by beat, expected peaks go to a
// scoreboard queue and are checked when peak_valid pulses.
module tb_fft_peak_finder;

    localparam int FRAME_LEN = 4096;

    logic        clk;
    logic        reset;
    logic        clear;
    logic [23:0] mag_tdata;
    logic [11:0] mag_tuser;
    logic        mag_tvalid;
    logic        mag_tlast;
    logic        mag_tready;
    logic [11:0] peak_bin;
    logic [23:0] peak_mag;
    logic [31:0] peak_hz;
    logic        peak_found;
    logic        peak_valid;
    logic        frame_err;
    logic [15:0] frame_cnt;

    fft_peak_finder dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .mag_tdata  (mag_tdata),
        .mag_tuser  (mag_tuser),
        .mag_tvalid (mag_tvalid),
        .mag_tlast  (mag_tlast),
        .mag_tready (mag_tready),
        .peak_bin   (peak_bin),
        .peak_mag   (peak_mag),
        .peak_hz    (peak_hz),
        .peak_found (peak_found),
        .peak_valid (peak_valid),
        .frame_err  (frame_err),
        .frame_cnt  (frame_cnt)
    );

    typedef struct {
        longint bin;
        longint mag;
        longint hz;
        longint found;
        longint cnt;
        longint t0;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    longint      cyc = 0;
    longint      exp_cnt = 0;
    longint      last_bin = 0, last_mag = 0, last_hz = 0, last_found = 0;
    logic [23:0] mags [FRAME_LEN];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (peak_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_peak_valid", 64'(peak_valid), 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("latency",    64'(cyc - e.t0), 64'd2);
                chk("peak_bin",   64'(peak_bin),   64'(e.bin));
                chk("peak_mag",   64'(peak_mag),   64'(e.mag));
                chk("peak_hz",    64'(peak_hz),    64'(e.hz));
                chk("peak_found", 64'(peak_found), 64'(e.found));
                chk("frame_cnt",  64'(frame_cnt),  64'(e.cnt));
                last_bin   = e.bin;
                last_mag   = e.mag;
                last_hz    = e.hz;
                last_found = e.found;
            end
        end
    end

    // Reference peak search over the in-band bins
    function automatic exp_t model();
        exp_t   e;
        longint bm = 0, bb = 0;
        for (int b = 1; b <= 2047; b++) begin
            if (longint'(mags[b]) > bm) begin
                bm = longint'(mags[b]);
                bb = b;
            end
        end
        e.found = (bm >= 256) ? 1 : 0;
        e.bin   = e.found != 0 ? bb : 0;
        e.mag   = e.found != 0 ? bm : 0;
        e.hz    = (e.bin * 768000) / 65536;
        e.cnt   = 0;
        e.t0    = 0;
        return e;
    endfunction

    task automatic fill(input logic [23:0] base);
        for (int i = 0; i < FRAME_LEN; i++) mags[i] = base;
    endtask

    task automatic beat(input int idx, input bit gaps);
        if (gaps) begin
            mag_tvalid = 1'b0;
            repeat ($urandom_range(0, 1)) @(negedge clk);
        end
        mag_tvalid = 1'b1;
        mag_tuser  = 12'(idx);
        mag_tdata  = mags[idx];
        mag_tlast  = (idx == FRAME_LEN - 1);
        @(negedge clk);
        mag_tvalid = 1'b0;
        mag_tlast  = 1'b0;
    endtask

    task automatic send_frame(input int skip, input bit gaps);
        exp_t e;
        for (int i = 0; i < FRAME_LEN; i++) begin
            if (i != skip) beat(i, gaps);
        end
        if (skip < 0) begin
            e       = model();
            exp_cnt = (exp_cnt + 1) % 65536;
            e.cnt   = exp_cnt;
            e.t0    = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic drain(input string tag);
        repeat (5) @(negedge clk);
        chk(tag, 64'(sb.size()), 64'd0);
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_bin"},   64'(peak_bin),   64'd0);
        chk({tag, "_mag"},   64'(peak_mag),   64'd0);
        chk({tag, "_hz"},    64'(peak_hz),    64'd0);
        chk({tag, "_found"}, 64'(peak_found), 64'd0);
        chk({tag, "_valid"}, 64'(peak_valid), 64'd0);
        chk({tag, "_err"},   64'(frame_err),  64'd0);
        chk({tag, "_cnt"},   64'(frame_cnt),  64'd0);
        chk({tag, "_ready"}, 64'(mag_tready), 64'd0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        clear      = 1'b0;
        mag_tdata  = '0;
        mag_tuser  = '0;
        mag_tvalid = 1'b0;
        mag_tlast  = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero_outputs("reset");
        reset = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", 64'(mag_tready), 64'd1);

        // Single tone at bin 36
        fill(24'd10);
        mags[36] = 24'd5000;
        send_frame(-1, 1'b0);
        drain("tone_drain");

        // Out-of-band giants, tie between 100 and 200
        fill(24'd10);
        mags[0]    = 24'd90000;
        mags[3000] = 24'd80000;
        mags[100]  = 24'd7000;
        mags[200]  = 24'd7000;
        send_frame(-1, 1'b0);
        drain("band_drain");

        // Below threshold
        fill(24'd10);
        mags[500] = 24'd255;
        send_frame(-1, 1'b0);
        drain("thresh_drain");

        // Back-to-back frames with tvalid gaps
        fill(24'd10);
        mags[36] = 24'd5000;
        send_frame(-1, 1'b1);
        fill(24'd10);
        mags[1000] = 24'd6000;
        send_frame(-1, 1'b1);
        drain("b2b_drain");
        chk("b2b_last_hz", 64'(peak_hz), 64'd11718);

        // Frame missing index 50 is dropped
        fill(24'd10);
        mags[60] = 24'd9999;
        send_frame(50, 1'b0);
        drain("skip_drain");
        chk("skip_err",   64'(frame_err),  64'd1);
        chk("skip_bin",   64'(peak_bin),   64'(last_bin));
        chk("skip_mag",   64'(peak_mag),   64'(last_mag));
        chk("skip_hz",    64'(peak_hz),    64'(last_hz));
        chk("skip_found", 64'(peak_found), 64'(last_found));
        chk("skip_cnt",   64'(frame_cnt),  64'(exp_cnt));

        fill(24'd10);
        mags[777] = 24'd9000;
        send_frame(-1, 1'b0);
        drain("recover_drain");
        chk("err_sticky", 64'(frame_err), 64'd1);

        clear = 1'b1;
        @(negedge clk);
        clear   = 1'b0;
        exp_cnt = 0;
        chk("clear_err", 64'(frame_err), 64'd0);
        chk("clear_cnt", 64'(frame_cnt), 64'd0);

        // Async reset while bin 2000 is on the bus
        fill(24'd10);
        mags[1500] = 24'd12345;
        for (int i = 0; i < 2000; i++) beat(i, 1'b0);
        mag_tvalid = 1'b1;
        mag_tuser  = 12'd2000;
        mag_tdata  = mags[2000];
        #2 reset = 1'b1;
        #1 chk_zero_outputs("async_reset");
        mag_tvalid = 1'b0;
        exp_cnt    = 0;
        last_bin   = 0;
        last_mag   = 0;
        last_hz    = 0;
        last_found = 0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int i = 2001; i < FRAME_LEN; i++) beat(i, 1'b0);
        drain("tail_drain");
        chk("tail_bin", 64'(peak_bin), 64'd0);
        chk("tail_cnt", 64'(frame_cnt), 64'd0);
        send_frame(-1, 1'b0);
        drain("post_reset_drain");
        chk("post_reset_cnt", 64'(frame_cnt), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
